// File: rtl/ahb_cfg_pkg.sv
// Shared constants and types for the AHB configuration slave and its job controller.
package ahb_cfg_pkg;

  // Write-side register addresses (word addresses, bits [2:0] of the bus address)
  localparam logic [2:0] ADDR_SIZE_W = 3'd0;
  localparam logic [2:0] ADDR_RBASE  = 3'd1;
  localparam logic [2:0] ADDR_WBASE  = 3'd2;

  // Read-side register addresses; STATUS shares slot 0 with the SIZE write port
  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_SIZE_R = 3'd3;
  localparam logic [2:0] ADDR_JOBS   = 3'd4;

  // Value returned by a STATUS read while a job is running
  localparam logic [31:0] STATUS_BUSY = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2
  } job_state_t;

  // An image is processable only if both sides fit the 3x3 kernel (or the configured minimum)
  function automatic logic size_legal(input logic [15:0] width,
                                      input logic [15:0] height,
                                      input int unsigned min_dim);
    return (32'(width) >= min_dim) && (32'(height) >= min_dim);
  endfunction

endpackage

// File: rtl/ahb_config_slave_if.sv
// Host-facing AHB-lite-style bus bundle for the configuration slave.
interface ahb_config_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] s_haddr;
  logic              s_hwrite;
  logic [DATA_W-1:0] s_hwdata;
  logic [DATA_W-1:0] s_hrdata;
  logic              s_hready;

  modport master (
    output s_haddr,
    output s_hwrite,
    output s_hwdata,
    input  s_hrdata,
    input  s_hready
  );

  modport slave (
    input  s_haddr,
    input  s_hwrite,
    input  s_hwdata,
    output s_hrdata,
    output s_hready
  );

endinterface

// File: rtl/cfg_job_ctrl.sv
// Job sequencer: turns a legal launch request into a one-cycle start pulse,
// holds busy until the core reports completion, and counts finished jobs.
module cfg_job_ctrl
  import ahb_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        launch_req,
  input  logic        core_done,
  output logic        start,
  output logic        busy,
  output logic [15:0] job_cnt
);

  job_state_t state;
  job_state_t state_next;
  logic       job_finished;

  // State register; reset drops any job in flight straight back to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and Moore outputs; core_done only matters once the core is really running
  always_comb begin
    state_next   = state;
    start        = 1'b0;
    busy         = 1'b0;
    job_finished = 1'b0;
    unique case (state)
      IDLE: begin
        if (launch_req) begin
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        start      = 1'b1;
        busy       = 1'b1;
        state_next = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (core_done) begin
          job_finished = 1'b1;
          state_next   = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Completed-job counter, free-running 16-bit wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_cnt <= 16'd0;
    end else if (job_finished) begin
      job_cnt <= job_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/ahb_config_slave.sv
// Register-mapped configuration slave: captures image geometry and pixel base
// addresses from the host, launches the filter core and reports status.
module ahb_config_slave
  import ahb_cfg_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MIN_DIM = 3
) (
  input  logic                clk,
  input  logic                rst,
  ahb_config_slave_if.slave   bus,
  output logic [15:0]         img_width,
  output logic [15:0]         img_height,
  output logic [31:0]         read_base,
  output logic [31:0]         write_base,
  output logic                start,
  input  logic                core_done,
  output logic                busy
);

  // Data-phase view of the transfer captured at the previous edge
  logic              dp_valid;
  logic              dp_write;
  logic [2:0]        dp_addr;
  logic              dp_status_rd;

  logic              err;
  logic [15:0]       job_cnt;
  logic [DATA_W-1:0] hrdata_q;
  logic [DATA_W-1:0] rd_next;

  logic [2:0]        ap_addr;
  logic              wr_commit;
  logic              wr_drop;
  logic              wr_size;
  logic              wr_rbase;
  logic              wr_wbase;
  logic              size_ok;
  logic              launch_req;
  logic              launch_bad;

  // Only the low three address bits select a register; the rest are don't-care
  logic              unused_haddr_hi;

  assign ap_addr         = bus.s_haddr[2:0];
  assign unused_haddr_hi = ^bus.s_haddr[ADDR_W-1:3];
  assign bus.s_hready    = 1'b1;
  assign bus.s_hrdata    = hrdata_q;

  // Address phase capture; every edge starts a new transfer, no wait states
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_valid     <= 1'b0;
      dp_write     <= 1'b0;
      dp_addr      <= 3'd0;
      dp_status_rd <= 1'b0;
    end else begin
      dp_valid     <= 1'b1;
      dp_write     <= bus.s_hwrite;
      dp_addr      <= ap_addr;
      dp_status_rd <= !bus.s_hwrite && (ap_addr == ADDR_STATUS) && !busy;
    end
  end

  // Decode the write finishing this cycle; a running job freezes the register file
  always_comb begin
    wr_commit  = dp_valid && dp_write && !busy;
    wr_drop    = dp_valid && dp_write && busy;
    wr_size    = wr_commit && (dp_addr == ADDR_SIZE_W);
    wr_rbase   = wr_commit && (dp_addr == ADDR_RBASE);
    wr_wbase   = wr_commit && (dp_addr == ADDR_WBASE);
    size_ok    = size_legal(img_width, img_height, MIN_DIM);
    launch_req = wr_wbase && size_ok;
    launch_bad = wr_wbase && !size_ok;
  end

  // Configuration registers, updated at the edge that ends the write data phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_width  <= 16'd0;
      img_height <= 16'd0;
      read_base  <= 32'd0;
      write_base <= 32'd0;
    end else begin
      if (wr_size) begin
        img_width  <= bus.s_hwdata[31:16];
        img_height <= bus.s_hwdata[15:0];
      end
      if (wr_rbase) begin
        read_base <= bus.s_hwdata;
      end
      if (wr_wbase) begin
        write_base <= bus.s_hwdata;
      end
    end
  end

  // Sticky error: set by a rejected write or an undersized launch, cleared by reading STATUS while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (wr_drop || launch_bad) begin
      err <= 1'b1;
    end else if (dp_valid && dp_status_rd) begin
      err <= 1'b0;
    end
  end

  // Read mux for the transfer in its address phase; a same-edge write to the same register is forwarded
  always_comb begin
    rd_next = '0;
    if (!bus.s_hwrite) begin
      unique case (ap_addr)
        ADDR_STATUS: rd_next = busy ? STATUS_BUSY : {31'd0, err};
        ADDR_RBASE:  rd_next = wr_rbase ? bus.s_hwdata : read_base;
        ADDR_WBASE:  rd_next = wr_wbase ? bus.s_hwdata : write_base;
        ADDR_SIZE_R: rd_next = wr_size  ? bus.s_hwdata : {img_width, img_height};
        ADDR_JOBS:   rd_next = {16'd0, job_cnt};
        default:     rd_next = '0;
      endcase
    end
  end

  // Registered read data, held stable for the whole data phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hrdata_q <= '0;
    end else begin
      hrdata_q <= rd_next;
    end
  end

  cfg_job_ctrl u_job_ctrl (
    .clk        (clk),
    .rst        (rst),
    .launch_req (launch_req),
    .core_done  (core_done),
    .start      (start),
    .busy       (busy),
    .job_cnt    (job_cnt)
  );

endmodule

// File: tb/tb_ahb_config_slave.sv
// Scoreboard bench for the AHB configuration slave: the driver queues expected
// read data, a monitor pops and compares it during each read data phase.
module tb_ahb_config_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_done;
  logic [15:0] img_width;
  logic [15:0] img_height;
  logic [31:0] read_base;
  logic [31:0] write_base;
  logic        start;
  logic        busy;

  ahb_config_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ahb_config_slave #(.ADDR_W(32), .DATA_W(32), .MIN_DIM(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .img_width  (img_width),
    .img_height (img_height),
    .read_base  (read_base),
    .write_base (write_base),
    .start      (start),
    .core_done  (core_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int          compared   = 0;
  int          mismatched = 0;
  int          start_cnt  = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] pend_data = 32'd0;
  logic        drv_chk   = 1'b0;
  logic        rd_pend;

  // One comparison: counts it, reports a FAIL line on disagreement
  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one transfer's address phase plus the previous write's data phase
  task automatic apply_stimulus(input logic wr, input logic [2:0] addr, input logic [31:0] wdata,
                                input logic chk, input logic [31:0] exp, input string name);
    @(negedge clk);
    bus.s_haddr  = {29'd0, addr};
    bus.s_hwrite = wr;
    bus.s_hwdata = pend_data;
    pend_data    = wr ? wdata : 32'd0;
    drv_chk      = chk & ~wr;
    if (chk && !wr) begin
      exp_q.push_back(exp);
      tag_q.push_back(name);
    end
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 3'd7, 32'd0, 1'b0, 32'd0, "idle");
  endtask

  task automatic write_reg(input logic [2:0] addr, input logic [31:0] data);
    apply_stimulus(1'b1, addr, data, 1'b0, 32'd0, "write");
  endtask

  task automatic read_reg(input logic [2:0] addr, input logic [31:0] exp, input string name);
    apply_stimulus(1'b0, addr, 32'd0, 1'b1, exp, name);
  endtask

  // Track which edges captured a checked read
  always @(posedge clk or posedge rst) begin
    if (rst) rd_pend <= 1'b0;
    else     rd_pend <= drv_chk;
  end

  // Monitor: compare read data mid data phase and count start pulses
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    string       t;
    if (start) start_cnt++;
    if (rd_pend && !rst) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL scoreboard_underflow: got read data %h expected no read", bus.s_hrdata);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_output(t, bus.s_hrdata, e);
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: time %0t expected finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    core_done    = 1'b0;
    bus.s_haddr  = 32'd7;
    bus.s_hwrite = 1'b0;
    bus.s_hwdata = 32'd0;
    #1;
    check_output("reset_hrdata", bus.s_hrdata, 32'd0);
    check_output("reset_hready", 32'(bus.s_hready), 32'd1);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_start", 32'(start), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] idle after reset");
    read_reg(3'd0, 32'd0, "idle_status");
    idle_cycle();
    idle_cycle();
    check_output("idle_hready", 32'(bus.s_hready), 32'd1);
    check_output("idle_busy", 32'(busy), 32'd0);
    check_output("idle_no_start", 32'(start_cnt), 32'd0);

    $display("[TB] configure and launch");
    write_reg(3'd0, {16'd64, 16'd48});
    write_reg(3'd1, 32'd1);
    write_reg(3'd2, 32'd200000);
    idle_cycle();
    idle_cycle();
    check_output("launch_start", 32'(start), 32'd1);
    check_output("launch_busy", 32'(busy), 32'd1);
    check_output("cfg_width", 32'(img_width), 32'd64);
    check_output("cfg_height", 32'(img_height), 32'd48);
    check_output("cfg_rbase", read_base, 32'd1);
    check_output("cfg_wbase", write_base, 32'd200000);
    idle_cycle();
    check_output("start_one_cycle", 32'(start), 32'd0);
    check_output("busy_hold", 32'(busy), 32'd1);
    read_reg(3'd0, 32'hFFFF_FFFF, "status_busy");
    idle_cycle();

    $display("[TB] completion");
    idle_cycle();
    core_done = 1'b1;
    check_output("busy_before_done", 32'(busy), 32'd1);
    idle_cycle();
    core_done = 1'b0;
    check_output("busy_after_done", 32'(busy), 32'd0);
    read_reg(3'd0, 32'd0, "status_idle");
    idle_cycle();
    read_reg(3'd4, 32'd1, "jobs_1");
    idle_cycle();
    idle_cycle();

    $display("[TB] illegal size");
    write_reg(3'd0, {16'd2, 16'd48});
    write_reg(3'd2, 32'h300);
    idle_cycle();
    read_reg(3'd0, 32'd1, "status_err");
    idle_cycle();
    read_reg(3'd0, 32'd0, "status_err_cleared");
    idle_cycle();
    idle_cycle();
    check_output("illegal_no_start", 32'(start_cnt), 32'd1);
    check_output("illegal_busy", 32'(busy), 32'd0);
    check_output("illegal_width", 32'(img_width), 32'd2);
    check_output("illegal_wbase", write_base, 32'h300);

    $display("[TB] write while busy");
    write_reg(3'd0, {16'd64, 16'd48});
    write_reg(3'd2, 32'd500);
    idle_cycle();
    idle_cycle();
    write_reg(3'd1, 32'd7);
    idle_cycle();
    read_reg(3'd1, 32'd1, "rbase_frozen");
    idle_cycle();
    check_output("rbase_port_frozen", read_base, 32'd1);
    core_done = 1'b1;
    idle_cycle();
    core_done = 1'b0;
    check_output("busy_after_done2", 32'(busy), 32'd0);
    read_reg(3'd0, 32'd1, "status_err_busy_write");
    idle_cycle();
    read_reg(3'd4, 32'd2, "jobs_2");
    idle_cycle();
    idle_cycle();

    $display("[TB] read forwarding");
    write_reg(3'd1, 32'h55);
    read_reg(3'd1, 32'h55, "fwd_rbase");
    write_reg(3'd0, {16'd32, 16'd20});
    read_reg(3'd3, {16'd32, 16'd20}, "fwd_size");
    idle_cycle();
    read_reg(3'd0, 32'd0, "status_after_fwd");
    idle_cycle();
    idle_cycle();

    $display("[TB] done on same edge as status read");
    write_reg(3'd2, 32'd900);
    idle_cycle();
    idle_cycle();
    idle_cycle();
    read_reg(3'd0, 32'hFFFF_FFFF, "status_done_same_edge");
    core_done = 1'b1;
    idle_cycle();
    core_done = 1'b0;
    check_output("busy_after_done3", 32'(busy), 32'd0);
    check_output("wbase_900", write_base, 32'd900);
    idle_cycle();
    core_done = 1'b1;
    idle_cycle();
    core_done = 1'b0;
    read_reg(3'd4, 32'd3, "jobs_3_idle_done_ignored");
    idle_cycle();
    idle_cycle();

    $display("[TB] reset mid job");
    write_reg(3'd2, 32'd1000);
    idle_cycle();
    idle_cycle();
    core_done = 1'b1;
    idle_cycle();
    core_done = 1'b0;
    check_output("launch_done_ignored", 32'(busy), 32'd1);
    apply_stimulus(1'b0, 3'd2, 32'd0, 1'b0, 32'd0, "preload");
    idle_cycle();
    check_output("hrdata_before_reset", bus.s_hrdata, 32'd1000);
    #2;
    rst = 1'b1;
    #1;
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_hrdata", bus.s_hrdata, 32'd0);
    check_output("rst_width", 32'(img_width), 32'd0);
    check_output("rst_rbase", read_base, 32'd0);
    check_output("rst_wbase", write_base, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    pend_data = 32'd0;
    idle_cycle();
    core_done = 1'b1;
    idle_cycle();
    core_done = 1'b0;
    read_reg(3'd4, 32'd0, "jobs_after_reset");
    idle_cycle();
    read_reg(3'd3, 32'd0, "size_after_reset");
    idle_cycle();
    idle_cycle();

    check_output("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    check_output("start_total", 32'(start_cnt), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ahb_config_slave.md
Name: ahb_config_slave

Overview:
- Register-mapped AHB-lite-style responder on the slave bus of the edge-detection top level.
- Accepts image geometry and source/destination base addresses from the host, and launches the filter core.
- Reports busy/idle and error status back to the host, and counts completed jobs.
- This is the slave end of the configuration protocol that the host bench drives.

Parameters:
- ADDR_W, 32, width of s_haddr.
- DATA_W, 32, width of s_hwdata/s_hrdata (fixed at 32; any other value is unsupported).
- MIN_DIM, 3, smallest legal image width/height (3x3 kernel).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_haddr  in  ADDR_W  register word address (address phase); only bits [2:0] decoded.
- s_hwrite  in  1  1=write, 0=read (address phase).
- s_hwdata  in  32  write data (data phase, one cycle after address).
- s_hrdata  out  32  read data (data phase).
- s_hready  out  1  transfer complete; always 1 outside reset.
- img_width  out  16  configured width.
- img_height  out  16  configured height.
- read_base  out  32  source pixel word address.
- write_base  out  32  destination pixel word address.
- start  out  1  one-cycle launch pulse to core.
- core_done  in  1  one-cycle completion pulse from core.
- busy  out  1  job in progress.

Behaviour:
- Reset (async, rst=1): all registers 0, start=0, busy=0, s_hrdata=0, s_hready=1, err=0, job_cnt=0; any pending data phase discarded.
- Pipelining: every rising edge captures s_haddr[2:0] and s_hwrite as the address phase. The following cycle is that transfer's data phase. Back-to-back transfers are allowed every cycle. No wait states.
- Write commit: the register is updated at the edge ending the data phase, using s_hwdata.
- Write map:
  - addr0 SIZE = {width[31:16], height[15:0]}
  - addr1 READ_BASE
  - addr2 WRITE_BASE, also launch request
  - others ignored
- Read map, s_hrdata registered, valid throughout the data phase:
  - addr0 STATUS: 32'hFFFF_FFFF when busy, else {31'b0, err}
  - addr1 READ_BASE
  - addr2 WRITE_BASE
  - addr3 SIZE
  - addr4 job_cnt
  - others 0
- Read forwarding: a read whose address phase coincides with a committing write to the same register returns the new value.
- Read side effect: reading STATUS while idle clears err at the end of its data phase.
- Job FSM states: IDLE, LAUNCH, BUSY.
  - IDLE -> LAUNCH on a WRITE_BASE commit when width>=MIN_DIM and height>=MIN_DIM.
  - Same commit with illegal size: err=1, stay IDLE.
  - LAUNCH: start=1 for exactly one cycle, busy=1; -> BUSY.
  - BUSY -> IDLE on core_done. busy drops the cycle after the done edge. job_cnt increments (16-bit wrap 0xFFFF->0, zero-extended on read).
- Writes to any register while LAUNCH/BUSY are dropped and set err; the register values stay stable during a job.
- core_done in IDLE/LAUNCH is ignored.
- core_done in the same edge as a STATUS read address phase: the read returns busy (pre-update value).
- Reset asserted mid-job: immediate return to IDLE, busy=0; the core is expected to be reset by the same rst.

Decomposition:
- Package ahb_cfg_pkg:
  - address constants ADDR_SIZE_W=0, ADDR_RBASE=1, ADDR_WBASE=2, ADDR_SIZE_R=3, ADDR_JOBS=4
  - STATUS_BUSY=32'hFFFF_FFFF
  - enum job_state_t {IDLE, LAUNCH, BUSY}
- Sub-module cfg_job_ctrl: FSM, start pulse, busy, job_cnt. The parent holds the bus pipeline, registers, and err.

Test Plan:
- Reset then idle: read addr0 -> s_hrdata=0, s_hready=1, busy=0, start never asserted.
- Configure and launch:
  - write addr0 data {16'd64,16'd48}, addr1 data 1, addr2 data 200000 back-to-back
  - -> img_width=64, img_height=48, read_base=1, write_base=200000
  - -> start high exactly one cycle after the addr2 data phase
  - -> read addr0 returns 32'hFFFF_FFFF.
- Completion: pulse core_done -> busy=0 next cycle; addr0 reads 0; addr4 reads 1.
- Illegal size: SIZE={16'd2,16'd48}, then write addr2 -> no start; addr0 reads 1; a second addr0 read returns 0.
- Write while busy: during a job, write addr1 data 7 -> addr1 still reads 1; after core_done, STATUS reads 1.
- Async reset mid-job: assert rst between clock edges while BUSY -> busy, registers, and s_hrdata go 0 immediately; a later core_done does not change job_cnt.
